// File: rtl/mcu_ld_ctrl.sv
// rtl/mcu_ld_ctrl.sv - M_CU load responder: per-element reads, in-order response alignment into the load buffer
// Optional perf counters (perf_cycles_o/perf_stall_o) are built when MCU_LD_PERF_CNT_EN is defined.
module mcu_ld_ctrl #(
  parameter int MAX_VL    = 64,
  parameter int MAX_OUTST = 4,
  parameter int ADDR_W    = 32
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      ld_vld_i,
  output logic                      ld_rdy_o,
  output logic                      ld_buffered_o,
  input  logic [ADDR_W-1:0]         base_addr_i,
  input  logic [31:0]               stride_i,
  input  logic [2:0]                data_width_i,
  input  logic                      unit_i,
  input  logic                      strided_i,
  input  logic                      idx_i,
  input  logic [$clog2(MAX_VL):0]   vl_i,
  output logic                      rd_req_vld_o,
  input  logic                      rd_req_rdy_i,
  output logic [ADDR_W-1:0]         rd_addr_o,
  input  logic                      rd_resp_vld_i,
  input  logic [31:0]               rd_resp_data_i,
  output logic                      buf_wr_en_o,
  output logic [$clog2(MAX_VL)-1:0] buf_wr_idx_o,
  output logic [31:0]               buf_wr_data_o,
  output logic                      err_o
`ifdef MCU_LD_PERF_CNT_EN
  ,
  output logic [31:0]               perf_cycles_o,
  output logic [31:0]               perf_stall_o
`endif
);

  localparam int VL_W  = $clog2(MAX_VL) + 1;
  localparam int IDX_W = $clog2(MAX_VL);
  localparam int OC_W  = $clog2(MAX_OUTST) + 1;
  localparam int PTR_W = $clog2(MAX_OUTST);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] step_q;
  logic [1:0]        align_mask_q;
  logic [31:0]       data_mask_q;
  logic [VL_W-1:0]   vl_q;
  logic [VL_W-1:0]   issued;
  logic [VL_W-1:0]   recv;
  logic [OC_W-1:0]   outst;
  logic [1:0]        off_fifo [MAX_OUTST];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              err_q;
  logic              done_pulse;

  logic              accept;
  logic              issue;
  logic              resp_ok;
  logic              stray_resp;
  logic              width_ok;
  logic [2:0]        es_new;
  logic [31:0]       mask_new;

  always_comb begin
    width_ok = 1'b1;
    es_new   = 3'd1;
    mask_new = 32'h0000_00ff;
    case (data_width_i)
      3'b000: begin es_new = 3'd1; mask_new = 32'h0000_00ff; end
      3'b101: begin es_new = 3'd2; mask_new = 32'h0000_ffff; end
      3'b110: begin es_new = 3'd4; mask_new = 32'hffff_ffff; end
      default: width_ok = 1'b0;
    endcase
  end

  assign ld_rdy_o      = (state == IDLE);
  assign accept        = ld_vld_i && ld_rdy_o;
  assign rd_req_vld_o  = (state == ISSUE) && (issued < vl_q) && (outst < OC_W'(MAX_OUTST));
  assign issue         = rd_req_vld_o && rd_req_rdy_i;
  assign resp_ok       = rd_resp_vld_i && (outst != '0);
  assign stray_resp    = rd_resp_vld_i && (outst == '0);
  assign rd_addr_o     = {cur_addr[ADDR_W-1:2], 2'b00};
  assign ld_buffered_o = done_pulse;
  assign err_o         = err_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      cur_addr      <= '0;
      step_q        <= '0;
      align_mask_q  <= '0;
      data_mask_q   <= '0;
      vl_q          <= '0;
      issued        <= '0;
      recv          <= '0;
      outst         <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      err_q         <= 1'b0;
      done_pulse    <= 1'b0;
      buf_wr_en_o   <= 1'b0;
      buf_wr_idx_o  <= '0;
      buf_wr_data_o <= '0;
      for (int i = 0; i < MAX_OUTST; i++) off_fifo[i] <= '0;
    end else begin
      buf_wr_en_o <= resp_ok;
      done_pulse  <= 1'b0;

      // Responses come back in issue order, so the FIFO head holds this word's byte offset.
      if (resp_ok) begin
        buf_wr_idx_o  <= recv[IDX_W-1:0];
        buf_wr_data_o <= (rd_resp_data_i >> {off_fifo[rd_ptr], 3'b000}) & data_mask_q;
        rd_ptr        <= rd_ptr + 1'b1;
        recv          <= recv + 1'b1;
      end
      if (stray_resp) err_q <= 1'b1;

      if (issue) begin
        off_fifo[wr_ptr] <= cur_addr[1:0];
        wr_ptr           <= wr_ptr + 1'b1;
        cur_addr         <= cur_addr + step_q;
        issued           <= issued + 1'b1;
        if ((cur_addr[1:0] & align_mask_q) != 2'b00) err_q <= 1'b1;
      end

      case ({issue, resp_ok})
        2'b10:   outst <= outst + 1'b1;
        2'b01:   outst <= outst - 1'b1;
        default: outst <= outst;
      endcase

      case (state)
        IDLE: begin
          if (accept) begin
            cur_addr     <= base_addr_i;
            step_q       <= (strided_i && !unit_i && !idx_i) ? ADDR_W'(stride_i) : ADDR_W'(es_new);
            align_mask_q <= 2'(es_new - 3'd1);
            data_mask_q  <= mask_new;
            vl_q         <= vl_i;
            issued       <= '0;
            recv         <= '0;
            err_q        <= !width_ok || stray_resp;
            state        <= (!width_ok || vl_i == '0) ? DONE : ISSUE;
          end
        end
        ISSUE: begin
          if (issue && issued == vl_q - VL_W'(1)) state <= DRAIN;
        end
        DRAIN: begin
          // The final write is registered this cycle, so the pulse lands one cycle after it.
          if ((resp_ok && recv == vl_q - VL_W'(1)) || recv == vl_q) state <= DONE;
        end
        DONE: begin
          done_pulse <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MCU_LD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_cycles_o <= '0;
      perf_stall_o  <= '0;
    end else if (accept) begin
      perf_cycles_o <= 32'd1;
      perf_stall_o  <= '0;
    end else begin
      if ((state != IDLE || done_pulse) && perf_cycles_o != '1) perf_cycles_o <= perf_cycles_o + 1'b1;
      if (rd_req_vld_o && !rd_req_rdy_i && perf_stall_o != '1) perf_stall_o <= perf_stall_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mcu_ld_ctrl.sv
// tb/tb_mcu_ld_ctrl.sv - self-checking bench for mcu_ld_ctrl with an in-order memory responder
module tb_mcu_ld_ctrl;
  localparam int MAX_VL    = 64;
  localparam int MAX_OUTST = 4;
  localparam int ADDR_W    = 32;
  localparam int VL_W      = $clog2(MAX_VL) + 1;
  localparam int IDX_W     = $clog2(MAX_VL);

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              ld_vld_i = 1'b0;
  logic              ld_rdy_o;
  logic              ld_buffered_o;
  logic [ADDR_W-1:0] base_addr_i = '0;
  logic [31:0]       stride_i = '0;
  logic [2:0]        data_width_i = '0;
  logic              unit_i = 1'b0;
  logic              strided_i = 1'b0;
  logic              idx_i = 1'b0;
  logic [VL_W-1:0]   vl_i = '0;
  logic              rd_req_vld_o;
  logic              rd_req_rdy_i = 1'b0;
  logic [ADDR_W-1:0] rd_addr_o;
  logic              rd_resp_vld_i = 1'b0;
  logic [31:0]       rd_resp_data_i = '0;
  logic              buf_wr_en_o;
  logic [IDX_W-1:0]  buf_wr_idx_o;
  logic [31:0]       buf_wr_data_o;
  logic              err_o;

  mcu_ld_ctrl #(.MAX_VL(MAX_VL), .MAX_OUTST(MAX_OUTST), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rstn(rstn), .ld_vld_i(ld_vld_i), .ld_rdy_o(ld_rdy_o), .ld_buffered_o(ld_buffered_o),
    .base_addr_i(base_addr_i), .stride_i(stride_i), .data_width_i(data_width_i),
    .unit_i(unit_i), .strided_i(strided_i), .idx_i(idx_i), .vl_i(vl_i),
    .rd_req_vld_o(rd_req_vld_o), .rd_req_rdy_i(rd_req_rdy_i), .rd_addr_o(rd_addr_o),
    .rd_resp_vld_i(rd_resp_vld_i), .rd_resp_data_i(rd_resp_data_i),
    .buf_wr_en_o(buf_wr_en_o), .buf_wr_idx_o(buf_wr_idx_o), .buf_wr_data_o(buf_wr_data_o),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;

  // Memory responder knobs: rdy_mode 0=always, 1=random, 2=never, 3=until issue_cap requests seen.
  int rdy_mode = 0, issue_cap = 0, lat_min = 2, lat_max = 2, resp_rand = 0, resp_budget = -1;
  logic [31:0] pend_addr[$];
  int          pend_due[$];

  logic [31:0] addr_q[$];
  int          widx_q[$];
  logic [31:0] wdat_q[$];
  int pulse_cnt = 0, pulse_cyc = -1, first_vld_cyc = -1, last_wr_cyc = -1, last_resp_cyc = -1;
  int acc_cyc = 0;

  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic        exp_err;
  logic        exp_ill;

  function automatic logic [31:0] mem_word(input logic [31:0] wa);
    return (wa * 32'h9E37_79B1) ^ 32'h5A5A_1234 ^ {wa[15:0], wa[31:16]};
  endfunction

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rd_req_vld_o && first_vld_cyc < 0) first_vld_cyc = cyc;
    if (buf_wr_en_o) begin
      widx_q.push_back(int'(buf_wr_idx_o));
      wdat_q.push_back(buf_wr_data_o);
      last_wr_cyc = cyc;
    end
    if (ld_buffered_o) begin
      pulse_cnt++;
      pulse_cyc = cyc;
    end
    case (rdy_mode)
      0:       rd_req_rdy_i = 1'b1;
      1:       rd_req_rdy_i = 1'($urandom_range(0, 1));
      2:       rd_req_rdy_i = 1'b0;
      default: rd_req_rdy_i = (addr_q.size() < issue_cap);
    endcase
    if (rd_req_vld_o && rd_req_rdy_i) begin
      addr_q.push_back(rd_addr_o);
      pend_addr.push_back(rd_addr_o);
      pend_due.push_back(cyc + int'($urandom_range(lat_min, lat_max)));
    end
    rd_resp_vld_i  = 1'b0;
    rd_resp_data_i = $urandom;
    if (pend_addr.size() > 0 && pend_due[0] <= cyc && resp_budget != 0 &&
        (resp_rand == 0 || $urandom_range(0, 1) == 1)) begin
      rd_resp_vld_i  = 1'b1;
      rd_resp_data_i = mem_word(pend_addr.pop_front());
      void'(pend_due.pop_front());
      if (resp_budget > 0) resp_budget--;
      last_resp_cyc = cyc;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_load(input string tag, input logic [31:0] base, input logic [31:0] stride,
                            input logic [2:0] w, input int mode, input int vl);
    int          es;
    logic [31:0] a, wa, stepv, mask;
    es = (w == 3'b000) ? 1 : (w == 3'b101) ? 2 : (w == 3'b110) ? 4 : 0;
    exp_ill = (es == 0);
    exp_err = exp_ill;
    exp_addr.delete();
    exp_data.delete();
    stepv = (mode == 1) ? stride : 32'(es);
    if (!exp_ill) begin
      for (int k = 0; k < vl; k++) begin
        a  = base + 32'(k) * stepv;
        if (a % 32'(es) != 0) exp_err = 1'b1;
        wa = a - (a % 32'd4);
        mask = (es == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * es)) - 32'd1);
        exp_addr.push_back(wa);
        exp_data.push_back((mem_word(wa) >> (8 * (a % 32'd4))) & mask);
      end
    end
    addr_q.delete(); widx_q.delete(); wdat_q.delete();
    pulse_cnt = 0; pulse_cyc = -1; first_vld_cyc = -1; last_wr_cyc = -1; last_resp_cyc = -1;
    chk({tag, "_rdy_before"}, ld_rdy_o, 1);
    base_addr_i = base; stride_i = stride; data_width_i = w; vl_i = VL_W'(vl);
    unit_i = (mode == 0); strided_i = (mode == 1); idx_i = (mode == 2);
    ld_vld_i = 1'b1;
    acc_cyc = cyc;
    tick();
    ld_vld_i = 1'b0;
    chk({tag, "_err_after_accept"}, err_o, exp_ill);
  endtask

  task automatic finish_load(input string tag);
    int t = 0;
    while (pulse_cnt == 0 && t < 3000) begin
      tick();
      t++;
    end
    chk({tag, "_done_in_time"}, t < 3000, 1);
    repeat (3) tick();
    chk({tag, "_pulse_cnt"}, pulse_cnt, 1);
    chk({tag, "_n_req"}, addr_q.size(), exp_addr.size());
    chk({tag, "_n_wr"}, wdat_q.size(), exp_data.size());
    for (int k = 0; k < exp_addr.size() && k < addr_q.size(); k++)
      chk($sformatf("%s_addr%0d", tag, k), addr_q[k], exp_addr[k]);
    for (int k = 0; k < exp_data.size() && k < wdat_q.size(); k++) begin
      chk($sformatf("%s_idx%0d", tag, k), widx_q[k], k);
      chk($sformatf("%s_data%0d", tag, k), wdat_q[k], exp_data[k]);
    end
    chk({tag, "_err"}, err_o, exp_err);
  endtask

  initial begin
    #1;
    chk("rst_rdy", ld_rdy_o, 1);
    chk("rst_req_vld", rd_req_vld_o, 0);
    chk("rst_buffered", ld_buffered_o, 0);
    chk("rst_wr_en", buf_wr_en_o, 0);
    chk("rst_err", err_o, 0);
    repeat (2) tick();
    rstn = 1'b1;
    tick();

    // Unit 32-bit load, always-ready memory, 2-cycle response latency
    start_load("unit", 32'h1000, 32'h0, 3'b110, 0, 4);
    finish_load("unit");
    chk("unit_a0_const", addr_q.size() > 3 ? addr_q[3] : 32'hX, 32'h100C);
    chk("unit_req_latency", first_vld_cyc - acc_cyc, 1);
    chk("unit_wr_latency", last_wr_cyc - last_resp_cyc, 1);
    chk("unit_pulse_latency", pulse_cyc - last_wr_cyc, 1);

    // Strided byte load crossing offsets
    start_load("strided", 32'h2001, 32'd3, 3'b000, 1, 3);
    finish_load("strided");
    chk("strided_a2_const", addr_q.size() > 2 ? addr_q[2] : 32'hX, 32'h2004);

    // Backpressure and outstanding-limit behaviour
    rdy_mode = 2; resp_budget = 0;
    start_load("bp", 32'h4000, 32'h0, 3'b110, 0, 8);
    repeat (5) tick();
    chk("bp_no_issue_while_stalled", addr_q.size(), 0);
    chk("bp_vld_held", rd_req_vld_o, 1);
    rdy_mode = 0;
    repeat (8) tick();
    chk("bp_issue_cap", addr_q.size(), MAX_OUTST);
    chk("bp_vld_low_at_cap", rd_req_vld_o, 0);
    resp_budget = 1;
    repeat (6) tick();
    chk("bp_one_more", addr_q.size(), MAX_OUTST + 1);
    chk("bp_vld_low_again", rd_req_vld_o, 0);
    resp_budget = 2;
    repeat (8) tick();
    chk("bp_two_more", addr_q.size(), MAX_OUTST + 3);
    resp_budget = -1;
    finish_load("bp");

    // Zero-length and illegal-width descriptors
    start_load("vl0", 32'h5000, 32'h0, 3'b110, 0, 0);
    finish_load("vl0");
    chk("vl0_pulse_timing", pulse_cyc - acc_cyc, 2);
    start_load("illw", 32'h5000, 32'h0, 3'b011, 0, 4);
    finish_load("illw");
    chk("illw_pulse_timing", pulse_cyc - acc_cyc, 2);

    // Misaligned word load; error must clear on the next accept
    start_load("misal", 32'h3002, 32'h0, 3'b110, 0, 2);
    finish_load("misal");
    start_load("clean", 32'h3100, 32'h0, 3'b101, 0, 3);
    finish_load("clean");

    // Reset with two reads outstanding
    rdy_mode = 3; issue_cap = 2; resp_budget = 0;
    start_load("rst", 32'h6000, 32'h0, 3'b110, 0, 8);
    repeat (6) tick();
    chk("rst_two_outst", addr_q.size(), 2);
    rstn = 1'b0;
    #1;
    chk("rst_mid_rdy", ld_rdy_o, 1);
    chk("rst_mid_req_vld", rd_req_vld_o, 0);
    chk("rst_mid_wr_en", buf_wr_en_o, 0);
    pend_addr.delete(); pend_due.delete();
    repeat (2) tick();
    rstn = 1'b1;
    pulse_cnt = 0;
    repeat (5) tick();
    chk("rst_no_pulse", pulse_cnt, 0);
    rdy_mode = 0; resp_budget = -1;
    start_load("post_rst", 32'h7000, 32'h0, 3'b110, 0, 5);
    finish_load("post_rst");

    // Randomized loads under random ready and response timing
    rdy_mode = 1; resp_rand = 1; lat_min = 1; lat_max = 4;
    for (int i = 0; i < 8; i++) begin
      logic [2:0]  w;
      logic [31:0] st;
      int          m;
      m  = int'($urandom_range(0, 2));
      w  = ($urandom_range(0, 2) == 0) ? 3'b000 : ($urandom_range(0, 1) == 0) ? 3'b101 : 3'b110;
      st = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : 32'($urandom_range(0, 9));
      start_load($sformatf("rnd%0d", i), $urandom, st, w, m, int'($urandom_range(1, 12)));
      finish_load($sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule

// File: doc/mcu_ld_ctrl.md
Name: mcu_ld_ctrl

Overview:
- M_CU-side responder for the scheduler's load handshake.
- Accepts one load descriptor per handshake: base, stride, width, mode flags and vl.
- Generates per-element read requests to the memory port, tracks outstanding reads, aligns and writes returned elements into the load buffer.
- Pulses ld_buffered_o once the whole vector is buffered.

Parameters:
- MAX_VL, 64, maximum element count; vl_i width is $clog2(MAX_VL)+1.
- MAX_OUTST, 4, maximum in-flight read requests; power of 2, at least 2.
- ADDR_W, 32, address width.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- ld_vld_i  in  1  load descriptor valid
- ld_rdy_o  out  1  ready to accept a descriptor
- ld_buffered_o  out  1  one-cycle pulse: all vl elements written to the buffer
- base_addr_i  in  ADDR_W  base address
- stride_i  in  32  byte stride, used only when strided_i=1
- data_width_i  in  3  RVV width code: 000=8b, 101=16b, 110=32b
- unit_i / strided_i / idx_i  in  1 each  addressing mode, one-hot
- vl_i  in  $clog2(MAX_VL)+1  element count
- rd_req_vld_o  out  1  read request valid
- rd_req_rdy_i  in  1  memory accepts the request
- rd_addr_o  out  ADDR_W  word-aligned address: element address with [1:0] forced to 0
- rd_resp_vld_i  in  1  read data valid; responses return in order
- rd_resp_data_i  in  32  read word
- buf_wr_en_o  out  1  buffer write strobe
- buf_wr_idx_o  out  $clog2(MAX_VL)  element index
- buf_wr_data_o  out  32  element, zero-extended, in the low bits
- err_o  out  1  sticky error; cleared on next descriptor accept

Behaviour:
- Reset: asynchronous, active-low, on rstn. All outputs 0, except ld_rdy_o=1 (IDLE). Counters, offset FIFO and address register cleared. Reset mid-operation aborts the load; no ld_buffered_o pulse is generated.
- Descriptor capture: on ld_vld_i && ld_rdy_o, capture all descriptor inputs.
- Element size: ES = 1, 2 or 4 bytes.
- Byte step: strided_i uses stride_i; unit_i and idx_i use ES.
- Illegal width code at capture: set err_o, enter DONE directly.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - ld_rdy_o=1.
  - On accept with vl_i=0: go to DONE.
  - On accept with vl_i>0: go to ISSUE, with cur_addr=base_addr_i and issued=0.
- ISSUE:
  - rd_req_vld_o=1 while issued<vl and outst<MAX_OUTST.
  - On rd_req_vld_o && rd_req_rdy_i: cur_addr += step (mod 2^ADDR_W, wraps silently), issued++, and push cur_addr[1:0] into the offset FIFO.
  - When issued reaches vl, go to DRAIN.
- Outstanding count: outst = issues minus responses. On a simultaneous issue and response in one cycle, the net change is 0; the limit is evaluated on the registered outst.
- Response handling, in any state:
  - On rd_resp_vld_i, pop the offset FIFO.
  - Next cycle: buf_wr_en_o=1, buf_wr_idx_o=recv count, and buf_wr_data_o = rd_resp_data_i >> (8*offset), masked to ES bytes.
  - Then recv++.
  - rd_resp_vld_i with outst=0 is ignored and sets err_o.
- Alignment: elements must be naturally aligned. A misaligned issued address sets err_o; the request is still issued and the data is extracted by truncation.
- DRAIN: wait until recv==vl and the last buffer write has completed, then go to DONE.
- DONE: ld_buffered_o=1 for exactly one cycle, then IDLE. ld_rdy_o=0 in DONE.
- Latency:
  - Accept to first rd_req_vld_o: 1 cycle.
  - Last response to buf_wr_en_o: 1 cycle.
  - buf_wr_en_o to ld_buffered_o: 1 cycle.
- rd_addr_o is held stable while rd_req_vld_o is high and not accepted.

Optional Feature:
- Macro MCU_LD_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_cycles_o [31:0] and perf_stall_o [31:0].
  - perf_cycles_o counts cycles from accept to the ld_buffered_o pulse, inclusive.
  - perf_stall_o counts cycles with rd_req_vld_o && !rd_req_rdy_i.
  - Both counters clear on accept, hold after DONE and saturate at all-ones.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Unit load, base 0x1000, width 110, vl=4, memory always ready, responses 2 cycles later -> addresses 0x1000/4/8/C, buffer idx 0..3 carry the response words, ld_buffered_o pulses once, err_o=0.
- Strided byte load, base 0x2001, stride 3, width 000, vl=3 -> rd_addr 0x2000, 0x2004, 0x2004; data bytes taken from offsets 1, 0, 3.
- Backpressure: rd_req_rdy_i=0 for 5 cycles, MAX_OUTST=4, responses withheld -> exactly 4 requests issued, then vld held low; releasing one response allows exactly one more issue. Simultaneous issue and response leaves outst unchanged.
- vl=0 accept -> no rd_req_vld_o, ld_buffered_o pulses 2 cycles after accept; illegal width 011 -> err_o=1 and the same timing.
- Misaligned 32-bit unit load at 0x3002, vl=2 -> err_o=1 (sticky); load completes; err_o clears on the next accept.
- Reset asserted while in ISSUE with 2 reads outstanding -> immediate IDLE, ld_rdy_o=1, no ld_buffered_o pulse; a following clean load completes normally.
